// File: rtl/iterative_alu.sv
// Multi-cycle integer ALU for the execute stage: single-cycle logic/compare ops plus an
// iterative shift-add multiplier and restoring divider sharing one hi/lo register pair.
module iterative_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero
);

    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0011;
    localparam logic [3:0] OP_OR    = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_SLT   = 4'b0110;
    localparam logic [3:0] OP_SLTU  = 4'b0111;
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam logic [3:0] OP_MULHU = 4'b1001;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             is_div_q;
    logic             hi_sel_q;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    logic [WIDTH-1:0] quick_result;
    logic             is_mul;
    logic             is_iter;
    logic [WIDTH:0]   msum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;
    logic [WIDTH-1:0] fin_result;

    always_comb begin
        quick_result = '0;
        case (alu_op)
            OP_ADD:  quick_result = src_a + src_b;
            OP_SUB:  quick_result = src_a - src_b;
            OP_OR:   quick_result = src_a | src_b;
            OP_AND:  quick_result = src_a & src_b;
            OP_SLT:  quick_result = WIDTH'($signed(src_a) < $signed(src_b));
            OP_SLTU: quick_result = WIDTH'(src_a < src_b);
            // Division by zero never enters the engine; RISC-V defines these results.
            OP_DIVU: quick_result = '1;
            OP_REMU: quick_result = src_a;
            default: quick_result = '0;
        endcase
    end

    assign is_mul  = (alu_op == OP_MUL) || (alu_op == OP_MULHU);
    assign is_iter = is_mul ||
                     (((alu_op == OP_DIVU) || (alu_op == OP_REMU)) && (src_b != '0));

    // Multiply: hi:lo holds partial product with the multiplier shifting out of lo.
    assign msum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

    // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
    assign shifted = {hi, lo[WIDTH-1]};
    assign ge      = (shifted >= {1'b0, opnd});
    assign diff    = shifted[WIDTH-1:0] - opnd;

    assign fin_result = hi_sel_q ? hi : lo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            is_div_q   <= 1'b0;
            hi_sel_q   <= 1'b0;
            opnd       <= '0;
            hi         <= '0;
            lo         <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            alu_result <= '0;
            zero       <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_iter) begin
                            is_div_q <= alu_op[2];
                            hi_sel_q <= alu_op[0];
                            opnd     <= is_mul ? src_a : src_b;
                            hi       <= '0;
                            lo       <= is_mul ? src_b : src_a;
                            cnt      <= '0;
                            busy     <= 1'b1;
                            state    <= CALC;
                        end else begin
                            alu_result <= quick_result;
                            zero       <= (quick_result == '0);
                            done       <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (is_div_q) begin
                        hi <= ge ? diff : shifted[WIDTH-1:0];
                        lo <= {lo[WIDTH-2:0], ge};
                    end else begin
                        hi <= msum[WIDTH:1];
                        lo <= {msum[0], lo[WIDTH-1:1]};
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1))
                        state <= FIN;
                end
                FIN: begin
                    alu_result <= fin_result;
                    zero       <= (fin_result == '0);
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_alu.sv
// Directed plus random bench for iterative_alu with an arithmetic reference model.
// Inputs driven and outputs sampled on the falling edge; DUT acts on the rising edge.
module tb_iterative_alu;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [3:0]   alu_op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         busy;
    logic         done;
    logic [W-1:0] alu_result;
    logic         zero;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    iterative_alu #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .alu_op     (alu_op),
        .src_a      (src_a),
        .src_b      (src_b),
        .busy       (busy),
        .done       (done),
        .alu_result (alu_result),
        .zero       (zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [W-1:0] ref_res(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [2*W-1:0] prod;
        prod = (2*W)'(a) * (2*W)'(b);
        case (op)
            4'b0010: return a + b;
            4'b0011: return a - b;
            4'b0100: return a | b;
            4'b0101: return a & b;
            4'b0110: return ($signed(a) < $signed(b)) ? 1 : 0;
            4'b0111: return (a < b) ? 1 : 0;
            4'b1000: return prod[W-1:0];
            4'b1001: return prod[2*W-1:W];
            4'b1100: return (b == 0) ? {W{1'b1}} : a / b;
            4'b1101: return (b == 0) ? a : a % b;
            default: return 0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [W-1:0] b);
        if (op == 4'b1000 || op == 4'b1001) return W + 2;
        if ((op == 4'b1100 || op == 4'b1101) && b != 0) return W + 2;
        return 1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        start  = 1'b1;
        alu_op = op;
        src_a  = a;
        src_b  = b;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        alu_op = 4'($urandom);
        src_a  = $urandom;
        src_b  = $urandom;
    endtask

    // Counts rising edges from the accept edge until done; notes whether busy held high.
    task automatic wait_done(input int lat0, output int lat, output bit busy_held);
        lat       = lat0;
        busy_held = 1'b1;
        while (!done && lat < 100) begin
            if (busy !== 1'b1) busy_held = 1'b0;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        logic [W-1:0] exp_r;
        int lat;
        bit busy_held;
        exp_r = ref_res(op, a, b);
        issue(op, a, b);
        wait_done(1, lat, busy_held);
        check({tag, "_latency"}, 64'(lat), 64'(ref_lat(op, b)));
        check({tag, "_result"}, 64'(alu_result), 64'(exp_r));
        check({tag, "_zero"}, 64'(zero), 64'(exp_r == 0));
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        if (ref_lat(op, b) > 1) check({tag, "_busy_held"}, 64'(busy_held), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    logic [3:0] ops[12] = '{4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
                            4'b1000, 4'b1001, 4'b1100, 4'b1101, 4'b1111, 4'b0000};

    initial begin
        int lat;
        bit busy_held;
        logic [3:0] op;
        logic [W-1:0] a, b;

        rst_n  = 1'b0;
        start  = 1'b0;
        alu_op = '0;
        src_a  = '0;
        src_b  = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", 64'(alu_result), 64'd0);
        check("reset_zero", 64'(zero), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("add_5_7", 4'b0010, 5, 7);
        run_op("sub_7_7", 4'b0011, 7, 7);
        run_op("slt_neg1_1", 4'b0110, 32'hFFFF_FFFF, 1);
        run_op("sltu_max_1", 4'b0111, 32'hFFFF_FFFF, 1);
        run_op("illegal_1111", 4'b1111, 32'h1234, 32'h5678);
        run_op("mul_max_2", 4'b1000, 32'hFFFF_FFFF, 2);
        run_op("mulhu_max_2", 4'b1001, 32'hFFFF_FFFF, 2);
        run_op("divu_100_7", 4'b1100, 100, 7);
        run_op("remu_100_7", 4'b1101, 100, 7);
        run_op("divu_100_0", 4'b1100, 100, 0);
        run_op("remu_100_0", 4'b1101, 100, 0);

        // A start during an iterative op must be ignored.
        issue(4'b1100, 1000, 9);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("hs_busy_mid", 64'(busy), 64'd1);
        start  = 1'b1;
        alu_op = 4'b0010;
        src_a  = 1;
        src_b  = 2;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        wait_done(5, lat, busy_held);
        check("hs_divu_latency", 64'(lat), 64'(W + 2));
        check("hs_divu_result", 64'(alu_result), 64'd111);
        // Start on the done cycle is accepted.
        issue(4'b0010, 20, 22);
        check("hs_add_done", 64'(done), 64'd1);
        check("hs_add_result", 64'(alu_result), 64'd42);
        @(posedge clk);
        @(negedge clk);
        check("hs_no_extra_done", 64'(done), 64'd0);

        // Back-to-back single-cycle ops produce done every cycle.
        for (int i = 1; i <= 4; i++) begin
            start  = 1'b1;
            alu_op = 4'b0011;
            src_a  = 32'(i * 100);
            src_b  = 32'(i);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("b2b_done_%0d", i), 64'(done), 64'd1);
            check($sformatf("b2b_result_%0d", i), 64'(alu_result), 64'(i * 99));
        end
        start = 1'b0;
        @(negedge clk);

        // Reset in the middle of a multiply.
        issue(4'b1000, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("rst_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        check("rst_mid_result", 64'(alu_result), 64'd0);
        check("rst_mid_zero", 64'(zero), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 4) begin
            @(negedge clk);
            if (done) check("rst_stray_done", 64'(done), 64'd0);
        end
        run_op("add_after_rst", 4'b0010, 32'h7FFF_FFFF, 1);

        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 11)];
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 0;
                1: b = $urandom_range(1, 15);
                2: a = $urandom_range(0, 255);
                default: ;
            endcase
            run_op($sformatf("rand%0d_op%0h", i, op), op, a, b);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
